// File: rtl/esc_passthrough_arbiter_pkg.sv
// Shared types and time-to-cycle helpers for the ESC passthrough arbiter.
// The state encoding doubles as the status-register value on state_o.
package esc_passthrough_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_DSHOT     = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_GUARD_IN  = 3'd2,
    ST_PASSTHRU  = 3'd3,
    ST_GUARD_OUT = 3'd4
  } arb_state_t;

  function automatic int US_TO_CYCLES(input int clk_hz, input int us);
    return (clk_hz / 1_000_000) * us;
  endfunction

  function automatic int MS_TO_CYCLES(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/esc_passthrough_arbiter_timer.sv
// Loadable down-counter with a done flag; stops at zero instead of wrapping.
// Used for both the guard interval and the passthrough inactivity timeout.
module esc_cycle_timer
  import esc_passthrough_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/esc_passthrough_arbiter.sv
// Hands one ESC signal pin from the DSHOT engine to the UART passthrough bridge
// and back, draining in-flight frames and holding the pin idle-high around each swap.
module esc_passthrough_arbiter
  import esc_passthrough_arbiter_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 72_000_000,
  parameter int NUM_MOTORS      = 4,
  parameter int GUARD_US        = 50,
  parameter int IDLE_TIMEOUT_MS = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pt_req,
  input  logic [$clog2(NUM_MOTORS)-1:0] pt_motor,
  input  logic [NUM_MOTORS-1:0]         dshot_busy,
  input  logic                          bridge_active,
  output logic [NUM_MOTORS-1:0]         dshot_en,
  output logic                          bridge_en,
  output logic [$clog2(NUM_MOTORS)-1:0] pin_sel,
  output logic [NUM_MOTORS-1:0]         pin_idle_high,
  output logic [2:0]                    state_o,
  output logic                          timeout_evt
);

  localparam int SEL_W         = $clog2(NUM_MOTORS);
  localparam int GUARD_CYCLES  = US_TO_CYCLES(CLK_FREQ_HZ, GUARD_US);
  localparam int TIMEOUT_LAST  = MS_TO_CYCLES(CLK_FREQ_HZ, IDLE_TIMEOUT_MS) - 1;
  localparam int GUARD_W       = $clog2(GUARD_CYCLES + 1);
  localparam int IDLE_W        = $clog2(TIMEOUT_LAST + 1);
  localparam logic [GUARD_W-1:0] GUARD_RELOAD = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [IDLE_W-1:0]  IDLE_RELOAD  = IDLE_W'(TIMEOUT_LAST);

  generate
    if (GUARD_CYCLES < 1) begin : g_guard_check
      $error("esc_passthrough_arbiter: guard interval resolves to zero cycles");
    end
  endgenerate

  arb_state_t       state;
  arb_state_t       state_next;
  logic [SEL_W-1:0] sel;
  logic             guard_load;
  logic             guard_done;
  logic             idle_load;
  logic             idle_done;
  logic             timeout_hit;

  logic [NUM_MOTORS-1:0] dshot_en_d;
  logic                  bridge_en_d;
  logic [NUM_MOTORS-1:0] pin_idle_high_d;
  logic                  timeout_evt_d;

  // The guard timer holds G-1 on the first guard cycle, so done marks the G-th cycle.
  esc_cycle_timer #(
    .WIDTH (GUARD_W)
  ) u_guard_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (guard_load),
    .load_value (GUARD_RELOAD),
    .done       (guard_done)
  );

  // Idle timer is held at T outside PASSTHRU and while the bridge is busy;
  // it reaches zero after T+1 silent cycles, matching an up-count reaching T.
  esc_cycle_timer #(
    .WIDTH (IDLE_W)
  ) u_idle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (idle_load),
    .load_value (IDLE_RELOAD),
    .done       (idle_done)
  );

  assign idle_load   = (state != ST_PASSTHRU) || bridge_active;
  assign timeout_hit = (state == ST_PASSTHRU) && !bridge_active && idle_done;

  always_comb begin
    state_next = state;
    case (state)
      ST_DSHOT: begin
        if (pt_req) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (dshot_busy == '0) state_next = ST_GUARD_IN;
      end
      ST_GUARD_IN: begin
        if (!pt_req) begin
          state_next = ST_GUARD_OUT;
        end else if (guard_done) begin
          state_next = ST_PASSTHRU;
        end
      end
      ST_PASSTHRU: begin
        // An active bridge keeps ownership so a byte in flight is never cut.
        if (timeout_hit || (!pt_req && !bridge_active)) state_next = ST_GUARD_OUT;
      end
      ST_GUARD_OUT: begin
        if (guard_done) state_next = ST_DSHOT;
      end
      default: state_next = ST_DSHOT;
    endcase
  end

  assign guard_load = (state_next != state) &&
                      ((state_next == ST_GUARD_IN) || (state_next == ST_GUARD_OUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DSHOT;
      sel   <= '0;
    end else begin
      state <= state_next;
      if ((state == ST_DSHOT) && pt_req) sel <= pt_motor;
    end
  end

  always_comb begin
    dshot_en_d      = '0;
    bridge_en_d     = 1'b0;
    pin_idle_high_d = '0;
    timeout_evt_d   = timeout_hit;
    case (state)
      ST_DSHOT:     dshot_en_d      = '1;
      ST_GUARD_IN:  pin_idle_high_d = NUM_MOTORS'(1) << sel;
      ST_PASSTHRU:  bridge_en_d     = 1'b1;
      ST_GUARD_OUT: pin_idle_high_d = NUM_MOTORS'(1) << sel;
      default:      dshot_en_d      = '0;
    endcase
  end

  // Every output is a register fed from the current state, giving a uniform
  // one-cycle lag; reset overrides them directly so the bridge drops at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      dshot_en      <= '1;
      bridge_en     <= 1'b0;
      pin_sel       <= '0;
      pin_idle_high <= '0;
      state_o       <= ST_DSHOT;
      timeout_evt   <= 1'b0;
    end else begin
      dshot_en      <= dshot_en_d;
      bridge_en     <= bridge_en_d;
      pin_sel       <= sel;
      pin_idle_high <= pin_idle_high_d;
      state_o       <= state;
      timeout_evt   <= timeout_evt_d;
    end
  end

endmodule

// File: tb/tb_esc_passthrough_arbiter.sv
// Self-checking bench for esc_passthrough_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a phase model.
module tb_esc_passthrough_arbiter;

  localparam int G = 10;
  localparam int T = 1999;
  localparam int S_DSHOT = 0;
  localparam int S_DRAIN = 1;
  localparam int S_GIN   = 2;
  localparam int S_PT    = 3;
  localparam int S_GOUT  = 4;

  logic       clk;
  logic       rst;
  logic       pt_req;
  logic [1:0] pt_motor;
  logic [3:0] dshot_busy;
  logic       bridge_active;
  logic [3:0] dshot_en;
  logic       bridge_en;
  logic [1:0] pin_sel;
  logic [3:0] pin_idle_high;
  logic [2:0] state_o;
  logic       timeout_evt;

  int n_vec = 0;
  int n_err = 0;

  esc_passthrough_arbiter #(
    .CLK_FREQ_HZ     (1_000_000),
    .NUM_MOTORS      (4),
    .GUARD_US        (10),
    .IDLE_TIMEOUT_MS (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pt_req        (pt_req),
    .pt_motor      (pt_motor),
    .dshot_busy    (dshot_busy),
    .bridge_active (bridge_active),
    .dshot_en      (dshot_en),
    .bridge_en     (bridge_en),
    .pin_sel       (pin_sel),
    .pin_idle_high (pin_idle_high),
    .state_o       (state_o),
    .timeout_evt   (timeout_evt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Phase model: which phase we are in and how many cycles it has lasted;
  // outputs reflect the phase of the previous cycle.
  int         m_state = S_DSHOT;
  int         m_cnt   = 0;
  logic [1:0] m_sel   = 2'd0;
  logic [3:0] e_dshot_en;
  logic       e_bridge_en;
  logic [1:0] e_pin_sel;
  logic [3:0] e_pin_idle;
  logic [2:0] e_state_o;
  logic       e_timeout;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state     <= S_DSHOT;
      m_cnt       <= 0;
      m_sel       <= 2'd0;
      e_dshot_en  <= 4'b1111;
      e_bridge_en <= 1'b0;
      e_pin_sel   <= 2'd0;
      e_pin_idle  <= 4'b0000;
      e_state_o   <= 3'd0;
      e_timeout   <= 1'b0;
      model_valid <= 1'b1;
    end else begin
      e_dshot_en  <= (m_state == S_DSHOT) ? 4'b1111 : 4'b0000;
      e_bridge_en <= (m_state == S_PT);
      e_pin_sel   <= m_sel;
      e_pin_idle  <= (m_state == S_GIN || m_state == S_GOUT) ? (4'b0001 << m_sel) : 4'b0000;
      e_state_o   <= 3'(m_state);
      e_timeout   <= (m_state == S_PT) && !bridge_active && (m_cnt == T);
      case (m_state)
        S_DSHOT: if (pt_req) begin m_sel <= pt_motor; m_state <= S_DRAIN; end
        S_DRAIN: if (dshot_busy == 4'b0000) begin m_state <= S_GIN; m_cnt <= 0; end
        S_GIN: begin
          if (!pt_req) begin m_state <= S_GOUT; m_cnt <= 0; end
          else if (m_cnt == G - 1) begin m_state <= S_PT; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        S_PT: begin
          if ((!bridge_active && m_cnt == T) || (!pt_req && !bridge_active)) begin
            m_state <= S_GOUT; m_cnt <= 0;
          end else if (bridge_active) m_cnt <= 0;
          else m_cnt <= m_cnt + 1;
        end
        default: begin
          if (m_cnt == G - 1) begin m_state <= S_DSHOT; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check_output("dshot_en", 32'(dshot_en), 32'(e_dshot_en));
      check_output("bridge_en", 32'(bridge_en), 32'(e_bridge_en));
      check_output("pin_sel", 32'(pin_sel), 32'(e_pin_sel));
      check_output("pin_idle_high", 32'(pin_idle_high), 32'(e_pin_idle));
      check_output("state_o", 32'(state_o), 32'(e_state_o));
      check_output("timeout_evt", 32'(timeout_evt), 32'(e_timeout));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    for (int i = 0; i < budget && state_o !== s; i++) @(negedge clk);
    check_output(name, 32'(state_o), 32'(s));
  endtask

  task automatic measure_state(input logic [2:0] s, input logic [3:0] pat, input int budget,
                               output int len, output int hits);
    len  = 0;
    hits = 0;
    while (state_o === s && len < budget) begin
      len++;
      if (pin_idle_high === pat) hits++;
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic req, input logic [1:0] motor,
                                input logic [3:0] busy, input logic active);
    pt_req        = req;
    pt_motor      = motor;
    dshot_busy    = busy;
    bridge_active = active;
  endtask

  initial begin
    int len, hits, evts, bad;
    rst = 1'b1;
    apply_stimulus(1'b0, 2'd0, 4'b0000, 1'b0);
    tick(3);
    check_output("rst_state", 32'(state_o), 0);
    check_output("rst_dshot_en", 32'(dshot_en), 32'hF);
    check_output("rst_bridge_en", 32'(bridge_en), 0);
    check_output("rst_pin_sel", 32'(pin_sel), 0);
    check_output("rst_idle_high", 32'(pin_idle_high), 0);
    check_output("rst_timeout", 32'(timeout_evt), 0);
    rst = 1'b0;
    tick(2);

    // Basic entry on motor 2, frozen selection, normal exit.
    apply_stimulus(1'b1, 2'd2, 4'b0000, 1'b0);
    wait_state(3'd2, 10, "basic_enter_guard");
    measure_state(3'd2, 4'b0100, 50, len, hits);
    check_output("guard_in_len", 32'(len), G);
    check_output("guard_in_pin", 32'(hits), G);
    check_output("pt_state", 32'(state_o), 3);
    check_output("pt_bridge_en", 32'(bridge_en), 1);
    check_output("pt_pin_sel", 32'(pin_sel), 2);
    pt_motor = 2'd1;
    tick(5);
    check_output("frozen_pin_sel", 32'(pin_sel), 2);
    pt_req = 1'b0;
    wait_state(3'd4, 5, "basic_exit_guard");
    measure_state(3'd4, 4'b0100, 50, len, hits);
    check_output("guard_out_len", 32'(len), G);
    check_output("guard_out_pin", 32'(hits), G);
    check_output("back_dshot_state", 32'(state_o), 0);
    check_output("back_dshot_en", 32'(dshot_en), 32'hF);
    tick(3);

    // Drain wait: busy motor 0 keeps us in DRAIN until it clears.
    apply_stimulus(1'b1, 2'd0, 4'b0001, 1'b0);
    tick(2);
    check_output("drain_dshot_en", 32'(dshot_en), 0);
    check_output("drain_state", 32'(state_o), 1);
    bad = 0;
    for (int i = 0; i < 28; i++) begin
      tick(1);
      if (state_o !== 3'd1) bad++;
    end
    check_output("drain_hold", 32'(bad), 0);
    dshot_busy = 4'b0000;
    wait_state(3'd2, 4, "drain_release");

    // Timeout with no bridge activity, then immediate re-request.
    wait_state(3'd3, 20, "to_enter_pt");
    len = 0;
    evts = 0;
    while (state_o === 3'd3 && len < 2100) begin
      len++;
      if (timeout_evt === 1'b1) evts++;
      tick(1);
    end
    check_output("to_pt_len", 32'(len), 2000);
    check_output("to_evt_count", 32'(evts), 1);
    measure_state(3'd4, 4'b0001, 50, len, hits);
    check_output("to_guard_out_len", 32'(len), G);
    check_output("to_dshot_en", 32'(dshot_en), 32'hF);
    tick(1);
    check_output("no_lockout", 32'(state_o), 1);
    pt_req = 1'b0;
    wait_state(3'd0, 40, "to_back_dshot");
    tick(3);

    // Periodic activity keeps passthrough alive; exit waits for activity to end.
    apply_stimulus(1'b1, 2'd3, 4'b0000, 1'b0);
    wait_state(3'd3, 20, "act_enter_pt");
    evts = 0;
    bad = 0;
    for (int i = 0; i < 6000; i++) begin
      bridge_active = ((i % 1500) == 1499);
      tick(1);
      if (timeout_evt === 1'b1) evts++;
      if (state_o !== 3'd3) bad++;
    end
    check_output("act_no_timeout", 32'(evts), 0);
    check_output("act_stayed", 32'(bad), 0);
    bridge_active = 1'b1;
    pt_req = 1'b0;
    tick(20);
    check_output("act_hold_pt", 32'(state_o), 3);
    bridge_active = 1'b0;
    tick(1);
    check_output("act_last_pt", 32'(state_o), 3);
    tick(1);
    check_output("act_exit", 32'(state_o), 4);
    wait_state(3'd0, 20, "act_back_dshot");
    tick(3);

    // Abort during the entry guard: bridge must never be enabled.
    apply_stimulus(1'b1, 2'd1, 4'b0000, 1'b0);
    wait_state(3'd2, 10, "abort_guard_in");
    pt_req = 1'b0;
    bad = 0;
    len = 0;
    for (int i = 0; i < 40 && state_o !== 3'd0; i++) begin
      tick(1);
      if (bridge_en !== 1'b0) bad++;
      if (state_o === 3'd4) len++;
    end
    check_output("abort_no_bridge", 32'(bad), 0);
    check_output("abort_guard_out", 32'(len), G);
    tick(3);

    // Reset in the middle of passthrough.
    apply_stimulus(1'b1, 2'd2, 4'b0000, 1'b0);
    wait_state(3'd3, 20, "rstpt_enter");
    tick(5);
    rst = 1'b1;
    tick(1);
    check_output("rstpt_bridge_en", 32'(bridge_en), 0);
    check_output("rstpt_state", 32'(state_o), 0);
    check_output("rstpt_dshot_en", 32'(dshot_en), 32'hF);
    rst = 1'b0;
    pt_req = 1'b0;
    tick(3);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 199) == 0) pt_req = ~pt_req;
      if ($urandom_range(0, 49) == 0) pt_motor = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0)
        dshot_busy = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if (bridge_active) begin
        if ($urandom_range(0, 4) == 0) bridge_active = 1'b0;
      end else if ($urandom_range(0, 799) == 0) begin
        bridge_active = 1'b1;
      end
      rst = ($urandom_range(0, 3999) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    n_err++;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
